// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: the 2-bit counter
// type, its named states and the table indexing modes.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating branch counter. Jumps force the
// counter straight to strongly-taken.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t counter,
    input  logic taken,
    input  logic force_max,
    output ctr_t next
);

    always_comb begin
        next = counter;
        if (force_max) begin
            next = ST;
        end else if (taken) begin
            if (counter != ST) next = counter + 2'd1;
        end else begin
            if (counter != SNT) next = counter - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, bimodal or gshare
// indexing, Execute-stage update, misprediction detection and perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int ENTRIES    = 64,
    parameter  int MODE       = 0,
    parameter  int HIST_WIDTH = 8,
    localparam int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    output logic [ADDR_WIDTH-1:0] pred_target_f,
    output logic [IDX_W-1:0]      pred_idx_f,
    input  logic                  upd_valid_e,
    input  logic [ADDR_WIDTH-1:0] upd_pc_e,
    input  logic [ADDR_WIDTH-1:0] upd_target_e,
    input  logic [IDX_W-1:0]      upd_idx_e,
    input  logic                  upd_taken_e,
    input  logic                  upd_is_jump_e,
    input  logic                  pred_taken_e,
    input  logic [ADDR_WIDTH-1:0] pred_target_e,
    output logic                  mispredict_e,
    output logic [ADDR_WIDTH-1:0] correct_pc_e,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispred_cnt
);

    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    logic                  valid_q  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    ctr_t                  ctr_q    [ENTRIES];
    logic [HIST_WIDTH-1:0] ghr_q;

    logic [IDX_W-1:0] ghr_ext;
    logic             hit_f;
    logic             upd_hit;
    ctr_t             ctr_next;

    // The low PC bits fall below instruction granularity and the update-side
    // index bits arrive already folded into upd_idx_e.
    logic unused_bits;
    assign unused_bits = ^{upd_pc_e[IDX_W+1:0], pc_f[1:0]};

    always_comb begin
        ghr_ext       = (MODE == MODE_GSHARE) ? IDX_W'(ghr_q) : '0;
        pred_idx_f    = pc_f[IDX_W+1:2] ^ ghr_ext;
        hit_f         = valid_q[pred_idx_f] && (tag_q[pred_idx_f] == pc_f[ADDR_WIDTH-1:IDX_W+2]);
        pred_taken_f  = hit_f && ctr_q[pred_idx_f][1];
        pred_target_f = pred_taken_f ? target_q[pred_idx_f] : pc_f + ADDR_WIDTH'(4);
    end

    always_comb begin
        upd_hit      = valid_q[upd_idx_e] && (tag_q[upd_idx_e] == upd_pc_e[ADDR_WIDTH-1:IDX_W+2]);
        mispredict_e = upd_valid_e &&
                       ((upd_taken_e != pred_taken_e) ||
                        (upd_taken_e && pred_taken_e && (upd_target_e != pred_target_e)));
        if (!upd_valid_e)     correct_pc_e = '0;
        else if (upd_taken_e) correct_pc_e = upd_target_e;
        else                  correct_pc_e = upd_pc_e + ADDR_WIDTH'(4);
    end

    bp_sat_counter u_sat_counter (
        .counter   (ctr_q[upd_idx_e]),
        .taken     (upd_taken_e),
        .force_max (upd_is_jump_e),
        .next      (ctr_next)
    );

    // Not-taken misses leave the table untouched so cold branches never
    // evict a useful entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (upd_valid_e) begin
            if (upd_hit) begin
                ctr_q[upd_idx_e] <= ctr_next;
                if (upd_taken_e) target_q[upd_idx_e] <= upd_target_e;
            end else if (upd_taken_e) begin
                valid_q[upd_idx_e]  <= 1'b1;
                tag_q[upd_idx_e]    <= upd_pc_e[ADDR_WIDTH-1:IDX_W+2];
                target_q[upd_idx_e] <= upd_target_e;
                ctr_q[upd_idx_e]    <= upd_is_jump_e ? ST : WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if ((MODE == MODE_GSHARE) && upd_valid_e && !upd_is_jump_e) begin
            ghr_q <= HIST_WIDTH'({ghr_q, upd_taken_e});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid_e && (branch_cnt != 32'hFFFF_FFFF))  branch_cnt  <= branch_cnt + 32'd1;
            if (mispredict_e && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share one
// directed stimulus stream and are compared every cycle against a table model.
module tb_branch_predictor;

    localparam int AW  = 32;
    localparam int NE  = 64;
    localparam int IW  = 6;
    localparam int HW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc_f = '0;
    logic          upd_valid_e = 1'b0;
    logic [AW-1:0] upd_pc_e = '0;
    logic [AW-1:0] upd_target_e = '0;
    logic [IW-1:0] upd_idx0 = '0;
    logic [IW-1:0] upd_idx1 = '0;
    logic          upd_taken_e = 1'b0;
    logic          upd_is_jump_e = 1'b0;
    logic          pred_taken_e = 1'b0;
    logic [AW-1:0] pred_target_e = '0;

    logic          pt0, pt1, mp0, mp1;
    logic [AW-1:0] ptg0, ptg1, cpc0, cpc1;
    logic [IW-1:0] pidx0, pidx1;
    logic [31:0]   bc0, bc1, mc0, mc1;

    int passed = 0;
    int total  = 0;

    // Model state: per instance, per entry
    bit            mv   [2][NE];
    logic [AW-1:0] mtag [2][NE];
    logic [AW-1:0] mtgt [2][NE];
    int            mcnt [2][NE];
    int            mghr [2];
    int            mbr  [2];
    int            mmis [2];
    bit            model_ready = 1'b0;

    always #5 clk = ~clk;

    branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(NE), .MODE(0), .HIST_WIDTH(HW)) dut0 (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pt0), .pred_target_f(ptg0), .pred_idx_f(pidx0),
        .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_target_e(upd_target_e),
        .upd_idx_e(upd_idx0), .upd_taken_e(upd_taken_e), .upd_is_jump_e(upd_is_jump_e),
        .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
        .mispredict_e(mp0), .correct_pc_e(cpc0), .branch_cnt(bc0), .mispred_cnt(mc0)
    );

    branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(NE), .MODE(1), .HIST_WIDTH(HW)) dut1 (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pt1), .pred_target_f(ptg1), .pred_idx_f(pidx1),
        .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_target_e(upd_target_e),
        .upd_idx_e(upd_idx1), .upd_taken_e(upd_taken_e), .upd_is_jump_e(upd_is_jump_e),
        .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
        .mispredict_e(mp1), .correct_pc_e(cpc1), .branch_cnt(bc1), .mispred_cnt(mc1)
    );

    function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] pc);
        return pc >> (IW + 2);
    endfunction

    function automatic logic [IW-1:0] model_idx(input int m, input logic [AW-1:0] pc);
        int i;
        i = (pc >> 2) % NE;
        if (m == 1) i = i ^ (mghr[1] % NE);
        return IW'(i);
    endfunction

    function automatic bit model_taken(input int m, input logic [AW-1:0] pc);
        int i;
        i = model_idx(m, pc);
        return mv[m][i] && (mtag[m][i] == tag_of(pc)) && (mcnt[m][i] >= 2);
    endfunction

    function automatic logic [AW-1:0] model_target(input int m, input logic [AW-1:0] pc);
        if (model_taken(m, pc)) return mtgt[m][model_idx(m, pc)];
        return pc + 32'd4;
    endfunction

    function automatic bit model_mispredict();
        if (!upd_valid_e) return 1'b0;
        if (upd_taken_e != pred_taken_e) return 1'b1;
        return upd_taken_e && (upd_target_e != pred_target_e);
    endfunction

    function automatic logic [AW-1:0] model_correct_pc();
        if (!upd_valid_e) return '0;
        return upd_taken_e ? upd_target_e : upd_pc_e + 32'd4;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] pc, input logic r, input logic v,
                                 input logic [AW-1:0] upc, input logic tk, input logic jp,
                                 input logic [AW-1:0] tgt);
        @(posedge clk);
        #1;
        rst           = r;
        pc_f          = pc;
        upd_valid_e   = v;
        upd_pc_e      = upc;
        upd_taken_e   = tk;
        upd_is_jump_e = jp;
        upd_target_e  = tgt;
        upd_idx0      = model_idx(0, upc);
        upd_idx1      = model_idx(1, upc);
        pred_taken_e  = model_taken(0, upc);
        pred_target_e = model_target(0, upc);
        @(negedge clk);
        #1;
    endtask

    // Model advances on each rising edge from the inputs held over the cycle
    always @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < NE; i++) begin
                    mv[m][i] = 1'b0; mtag[m][i] = '0; mtgt[m][i] = '0; mcnt[m][i] = 1;
                end
                mghr[m] = 0; mbr[m] = 0; mmis[m] = 0;
            end
            model_ready = 1'b1;
        end else if (upd_valid_e) begin
            for (int m = 0; m < 2; m++) begin
                int  i;
                bit  hit;
                i   = (m == 0) ? int'(upd_idx0) : int'(upd_idx1);
                hit = mv[m][i] && (mtag[m][i] == tag_of(upd_pc_e));
                if (model_mispredict()) mmis[m]++;
                mbr[m]++;
                if (hit) begin
                    if (upd_is_jump_e)    mcnt[m][i] = 3;
                    else if (upd_taken_e) mcnt[m][i] = (mcnt[m][i] < 3) ? mcnt[m][i] + 1 : 3;
                    else                  mcnt[m][i] = (mcnt[m][i] > 0) ? mcnt[m][i] - 1 : 0;
                    if (upd_taken_e) mtgt[m][i] = upd_target_e;
                end else if (upd_taken_e) begin
                    mv[m][i]   = 1'b1;
                    mtag[m][i] = tag_of(upd_pc_e);
                    mtgt[m][i] = upd_target_e;
                    mcnt[m][i] = upd_is_jump_e ? 3 : 2;
                end
                if (m == 1 && !upd_is_jump_e) mghr[1] = ((mghr[1] << 1) | int'(upd_taken_e)) % (1 << HW);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("pred_taken0",  {63'b0, pt0},  {63'b0, model_taken(0, pc_f)});
            checkOutput("pred_target0", {32'b0, ptg0}, {32'b0, model_target(0, pc_f)});
            checkOutput("pred_idx0",    {58'b0, pidx0}, {58'b0, model_idx(0, pc_f)});
            checkOutput("pred_taken1",  {63'b0, pt1},  {63'b0, model_taken(1, pc_f)});
            checkOutput("pred_target1", {32'b0, ptg1}, {32'b0, model_target(1, pc_f)});
            checkOutput("pred_idx1",    {58'b0, pidx1}, {58'b0, model_idx(1, pc_f)});
            checkOutput("mispredict0",  {63'b0, mp0},  {63'b0, model_mispredict()});
            checkOutput("mispredict1",  {63'b0, mp1},  {63'b0, model_mispredict()});
            checkOutput("correct_pc0",  {32'b0, cpc0}, {32'b0, model_correct_pc()});
            checkOutput("correct_pc1",  {32'b0, cpc1}, {32'b0, model_correct_pc()});
            checkOutput("branch_cnt0",  {32'b0, bc0},  64'(mbr[0]));
            checkOutput("branch_cnt1",  {32'b0, bc1},  64'(mbr[1]));
            checkOutput("mispred_cnt0", {32'b0, mc0},  64'(mmis[0]));
            checkOutput("mispred_cnt1", {32'b0, mc1},  64'(mmis[1]));
        end
    end

    initial begin
        $display("[TB] start");
        // Reset, then a taken update that collides with reset
        applyStimulus(32'h200, 1, 0, 32'h0,   0, 0, 32'h0);
        applyStimulus(32'h200, 1, 1, 32'h200, 1, 0, 32'h80);
        applyStimulus(32'h200, 0, 0, 32'h0,   0, 0, 32'h0);
        checkOutput("lit_rst_upd_taken",  {63'b0, pt0}, 64'd0);
        checkOutput("lit_rst_upd_target", {32'b0, ptg0}, 64'h204);
        checkOutput("lit_rst_branch_cnt", {32'b0, bc0}, 64'd0);
        checkOutput("lit_rst_mispred_cnt", {32'b0, mc0}, 64'd0);

        applyStimulus(32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_cold_taken",  {63'b0, pt0}, 64'd0);
        checkOutput("lit_cold_target", {32'b0, ptg0}, 64'h104);
        checkOutput("lit_cold_target1", {32'b0, ptg1}, 64'h104);

        // First taken update allocates; prediction in this cycle is pre-update
        applyStimulus(32'h100, 0, 1, 32'h100, 1, 0, 32'h40);
        checkOutput("lit_alloc_mispredict", {63'b0, mp0}, 64'd1);
        checkOutput("lit_alloc_correct_pc", {32'b0, cpc0}, 64'h40);
        checkOutput("lit_alloc_no_bypass",  {63'b0, pt0}, 64'd0);
        applyStimulus(32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_alloc_taken",  {63'b0, pt0}, 64'd1);
        checkOutput("lit_alloc_target", {32'b0, ptg0}, 64'h40);

        // Saturate up to 3, then four not-taken down to 0
        applyStimulus(32'h100, 0, 1, 32'h100, 1, 0, 32'h40);
        applyStimulus(32'h100, 0, 1, 32'h100, 1, 0, 32'h40);
        for (int k = 0; k < 4; k++) applyStimulus(32'h100, 0, 1, 32'h100, 0, 0, 32'h0);
        applyStimulus(32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_sat0_taken",   {63'b0, pt0}, 64'd0);
        checkOutput("lit_sat0_mispred", {32'b0, mc0}, 64'd3);
        checkOutput("lit_sat0_branch",  {32'b0, bc0}, 64'd7);

        // Alias: 0x1100 shares index 0 with 0x100 but has a different tag
        applyStimulus(32'h100, 0, 1, 32'h100,  1, 0, 32'h40);
        applyStimulus(32'h100, 0, 1, 32'h1100, 1, 0, 32'h80);
        applyStimulus(32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_alias_taken",  {63'b0, pt0}, 64'd0);
        checkOutput("lit_alias_target", {32'b0, ptg0}, 64'h104);
        applyStimulus(32'h1100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_alias_new_taken",  {63'b0, pt0}, 64'd1);
        checkOutput("lit_alias_new_target", {32'b0, ptg0}, 64'h80);
        checkOutput("lit_alias_mispred",    {32'b0, mc0}, 64'd5);

        // Gshare history: T,T,N gives 3'b110
        applyStimulus(32'h100, 1, 0, 32'h0, 0, 0, 32'h0);
        applyStimulus(32'h500, 0, 1, 32'h500, 1, 0, 32'h600);
        applyStimulus(32'h504, 0, 1, 32'h504, 1, 0, 32'h600);
        applyStimulus(32'h508, 0, 1, 32'h508, 0, 0, 32'h0);
        applyStimulus(32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_ghr_idx1", {58'b0, pidx1}, 64'd6);
        checkOutput("lit_ghr_idx0", {58'b0, pidx0}, 64'd0);

        // Jump allocates strongly taken and leaves history alone
        applyStimulus(32'h300, 0, 1, 32'h300, 1, 1, 32'h1000);
        applyStimulus(32'h300, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_jump_taken",  {63'b0, pt0}, 64'd1);
        checkOutput("lit_jump_target", {32'b0, ptg0}, 64'h1000);
        applyStimulus(32'h100, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_jump_ghr_hold", {58'b0, pidx1}, 64'd6);

        applyStimulus(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("lit_wrap_target", {32'b0, ptg0}, 64'h0);
        checkOutput("lit_idle_correct_pc", {32'b0, cpc0}, 64'h0);
        checkOutput("lit_idle_mispredict", {63'b0, mp0}, 64'd0);

        applyStimulus(32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, 32, PC width.
REQ-002 The block SHALL have parameter ENTRIES, 64, table depth; power of two, 4..1024; IDX_W = log2(ENTRIES).
REQ-003 The block SHALL have parameter MODE, 0, index mode: 0 = bimodal, 1 = gshare.
REQ-004 The block SHALL have parameter HIST_WIDTH, 8, global history bits; must be <= IDX_W; unused when MODE=0.
REQ-005 The block SHALL have one clock and a synchronous active-high reset; ports are named clk and rst.
REQ-006 Port clk  in  1  rising-edge clock.
REQ-007 Port rst  in  1  synchronous active-high reset.
REQ-008 Port pc_f  in  ADDR_WIDTH  fetch-stage PC.
REQ-009 Port pred_taken_f  out  1  predicted taken.
REQ-010 Port pred_target_f  out  ADDR_WIDTH  predicted target.
REQ-011 Port pred_idx_f  out  IDX_W  table index used; pipelined to Execute by the core.
REQ-012 Port upd_valid_e  in  1  resolved branch/jump in Execute.
REQ-013 Port upd_pc_e, upd_target_e  in  ADDR_WIDTH  resolved instruction PC and actual target.
REQ-014 Port upd_idx_e  in  IDX_W  pipelined pred_idx_f.
REQ-015 Port upd_taken_e, upd_is_jump_e, pred_taken_e  in  1  actual outcome, unconditional-jump flag, pipelined prediction.
REQ-016 Port pred_target_e  in  ADDR_WIDTH  pipelined prediction target.
REQ-017 Port mispredict_e  out  1  redirect/flush request.
REQ-018 Port correct_pc_e  out  ADDR_WIDTH  redirect PC.
REQ-019 Port branch_cnt, mispred_cnt  out  32  performance counters.

Function
REQ-020 Each entry SHALL hold: valid, tag = pc[ADDR_WIDTH-1:IDX_W+2], target (ADDR_WIDTH), 2-bit saturating counter.
REQ-021 Index SHALL be pc_f[IDX_W+1:2] when MODE=0, and pc_f[IDX_W+1:2] XOR zero-extended GHR when MODE=1.
REQ-022 Prediction SHALL be combinational, zero latency: pred_taken_f = valid AND tag match AND counter[1].
REQ-023 pred_target_f SHALL be the stored target when pred_taken_f=1, otherwise pc_f+4.
REQ-024 Updates SHALL write only at the clk edge with upd_valid_e=1, at entry upd_idx_e.
REQ-025 On a hit, the counter SHALL increment if taken and decrement if not taken, saturating at 3 and 0.
REQ-026 On a hit with taken=1, the target SHALL be overwritten with upd_target_e.
REQ-027 On a miss with taken=1, the entry SHALL be allocated: valid=1, new tag, target, counter=2 (weak taken).
REQ-028 On a miss with taken=0, there SHALL be no allocation and no change.
REQ-029 When upd_is_jump_e=1, the counter SHALL be set to 3 regardless of previous value.
REQ-030 GHR SHALL shift left by one with upd_taken_e inserted at LSB on each conditional update (upd_is_jump_e=0), MODE=1 only; it holds otherwise.
REQ-031 mispredict_e = upd_valid_e AND ((upd_taken_e != pred_taken_e) OR (both taken AND upd_target_e != pred_target_e)); combinational.
REQ-032 correct_pc_e SHALL be upd_target_e if upd_taken_e, else upd_pc_e+4; it is 0 when upd_valid_e=0.
REQ-033 When predict and update hit the same index in the same cycle, the prediction SHALL use the pre-update contents (no bypass).
REQ-034 branch_cnt SHALL increment per upd_valid_e and mispred_cnt per mispredict_e; both saturate at 32'hFFFFFFFF.
REQ-035 PC arithmetic SHALL be modulo 2^ADDR_WIDTH; pc_f+4 wraps.

Reset
REQ-036 On rst=1 at a clk edge: all valid=0, counters=1 (weak not-taken), targets=0, GHR=0, branch_cnt=0, mispred_cnt=0.
REQ-037 rst SHALL take priority over a simultaneous update; the update is discarded.
REQ-038 After reset, pred_taken_f=0 and pred_target_f=pc_f+4 for all PCs until an allocation occurs.

Structure
REQ-039 Package bp_pkg SHALL hold the counter typedef, counter constants (SNT=0, WNT=1, WT=2, ST=3) and the MODE encodings.
REQ-040 The counter next-state logic SHALL be the sub-module bp_sat_counter (combinational: counter, taken, force_max -> next counter).
REQ-041 Table storage SHALL be flip-flop arrays with asynchronous read; no memory macros.

Verification
REQ-042 After reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104.
REQ-043 Taken update with pc=0x100, target=0x40 -> next cycle pc_f=0x100 gives pred_taken_f=1, target 0x40; mispredict_e=1 and correct_pc_e=0x40 during the update.
REQ-044 Four not-taken updates on an entry at counter 3 -> counter 0 (saturates at 0); pred_taken_f=0; mispred_cnt increments on the first two only.
REQ-045 With ENTRIES=64, allocate 0x100, then allocate 0x1100 (same index, different tag) -> 0x100 misses and predicts 0x104.
REQ-046 MODE=1: updates of T,T,N -> GHR=3'b110 in the low bits; pred_idx_f = pc index XOR 6.
REQ-047 rst asserted in the same cycle as a taken update -> entry remains invalid and counters read 0.
